// File: rtl/adc_frame_pkg.sv
// adc_frame_packer shared types and helpers.
// Channel helpers work on 16-channel, 16-bit-length vectors; callers zero-extend.
package adc_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    HEAD,
    CHID,
    DATA,
    DRAIN,
    CSUM,
    DONE
  } state_t;

  localparam logic [7:0] HEAD0_DEF = 8'h55;
  localparam logic [7:0] HEAD1_DEF = 8'hAA;
  localparam int MAX_FRAME = 4095;
  localparam int MAX_CH = 16;
  localparam int MAX_LW = 16;

  function automatic logic [4:0] next_ch(
    input logic [MAX_CH-1:0] mask,
    input logic [4:0]        from,
    input int                n
  );
    logic [4:0] r;
    r = 5'(n);
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (i < n && 5'(i) >= from && mask[i]) r = 5'(i);
    end
    return r;
  endfunction

  // Saturates so an oversize frame can never wrap back into range.
  function automatic logic [12:0] frame_len(
    input logic [MAX_CH-1:0]        mask,
    input logic [MAX_CH*MAX_LW-1:0] lens,
    input int                       n
  );
    int t;
    t = 6;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < n && mask[i]) begin
        t = t + 1 + int'(32'(lens[i*MAX_LW +: MAX_LW]));
      end
    end
    return (t > 8191) ? 13'h1FFF : 13'(t);
  endfunction

endpackage

// File: rtl/adc_frame_packer.sv
// Packs masked per-channel ADC byte streams into one framed packet
// (header, channel IDs, payload, checksum) written into fifod.
module adc_frame_packer
  import adc_frame_pkg::*;
#(
  parameter int         NUM_CH = 4,
  parameter int         LEN_W  = 10,
  parameter logic [7:0] HEAD0  = HEAD0_DEF,
  parameter logic [7:0] HEAD1  = HEAD1_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fs,
  output logic                    fd,
  output logic                    err,
  input  logic [7:0]              dev_kind,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [NUM_CH*LEN_W-1:0] ch_len,
  output logic [NUM_CH-1:0]       ch_rxen,
  input  logic [NUM_CH*8-1:0]     ch_rxd,
  input  logic                    fifod_full,
  output logic                    fifod_txen,
  output logic [7:0]              fifod_txd,
  output logic [11:0]             data_len
);

  state_t state, state_n;

  logic [7:0]              seq;
  logic [NUM_CH-1:0]       mask_q;
  logic [NUM_CH*LEN_W-1:0] lens_q;
  logic [4:0]              ch;
  logic [LEN_W-1:0]        cnt;
  logic [7:0]              csum;
  logic [2:0]              hidx;
  logic                    pend;

  logic [MAX_CH-1:0]        mask16;
  logic [MAX_CH*MAX_LW-1:0] lens16;
  logic [12:0]              total;
  logic                     bad;
  logic [4:0]               nxt_ch;
  logic [4:0]               first_ch;
  logic [LEN_W-1:0]         cur_len;
  logic [7:0]               cur_rxd;
  logic [7:0]               hbyte;
  logic                     rd;

  always_comb begin
    mask16 = 16'(mask_q);
    lens16 = '0;
    cur_len = '0;
    cur_rxd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      lens16[i*MAX_LW +: MAX_LW] = 16'(lens_q[i*LEN_W +: LEN_W]);
      if (ch == 5'(i)) begin
        cur_len = lens_q[i*LEN_W +: LEN_W];
        cur_rxd = ch_rxd[i*8 +: 8];
      end
    end
    total    = frame_len(mask16, lens16, NUM_CH);
    bad      = (mask_q == '0) || (total > 13'(MAX_FRAME));
    nxt_ch   = next_ch(mask16, ch + 5'd1, NUM_CH);
    first_ch = next_ch(mask16, 5'd0, NUM_CH);
  end

  always_comb begin
    unique case (hidx)
      3'd0:    hbyte = HEAD0;
      3'd1:    hbyte = HEAD1;
      3'd2:    hbyte = dev_kind;
      3'd3:    hbyte = seq;
      default: hbyte = 8'(mask_q);
    endcase
  end

  assign rd = (state == DATA) && (cnt != '0) && !fifod_full;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (fs) state_n = LATCH;
      LATCH: state_n = bad ? DONE : HEAD;
      HEAD:  if (!fifod_full && hidx == 3'd4) state_n = CHID;
      CHID: begin
        if (!fifod_full) begin
          if (cur_len != '0)                state_n = DATA;
          else if (nxt_ch == 5'(NUM_CH))    state_n = CSUM;
        end
      end
      DATA:  if (rd && cnt == LEN_W'(1)) state_n = DRAIN;
      DRAIN: state_n = (nxt_ch == 5'(NUM_CH)) ? CSUM : CHID;
      CSUM:  if (!fifod_full) state_n = DONE;
      DONE:  if (!fs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ch_rxen    = '0;
    fifod_txen = 1'b0;
    fifod_txd  = 8'h00;
    fd         = (state == DONE);
    for (int i = 0; i < NUM_CH; i++) begin
      ch_rxen[i] = rd && (ch == 5'(i));
    end
    unique case (state)
      HEAD: begin
        fifod_txen = !fifod_full;
        fifod_txd  = hbyte;
      end
      CHID: begin
        fifod_txen = !fifod_full;
        fifod_txd  = 8'(ch);
      end
      DATA, DRAIN: begin
        fifod_txen = pend;
        fifod_txd  = pend ? cur_rxd : 8'h00;
      end
      CSUM: begin
        fifod_txen = !fifod_full;
        fifod_txd  = csum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq      <= '0;
      mask_q   <= '0;
      lens_q   <= '0;
      ch       <= '0;
      cnt      <= '0;
      csum     <= '0;
      hidx     <= '0;
      pend     <= 1'b0;
      data_len <= '0;
      err      <= 1'b0;
    end else begin
      pend <= rd;
      // HEAD0/HEAD1 and the checksum byte itself stay out of the sum.
      if (fifod_txen && !(state == HEAD && hidx < 3'd2) && state != CSUM)
        csum <= csum + fifod_txd;
      unique case (state)
        IDLE: begin
          if (fs) begin
            mask_q <= ch_mask;
            lens_q <= ch_len;
            err    <= 1'b0;
            csum   <= '0;
          end
        end
        LATCH: begin
          if (bad) begin
            err      <= 1'b1;
            data_len <= '0;
          end else begin
            data_len <= total[11:0];
          end
          hidx <= '0;
          ch   <= first_ch;
        end
        HEAD: if (!fifod_full) hidx <= hidx + 3'd1;
        CHID: begin
          if (!fifod_full) begin
            if (cur_len != '0) cnt <= cur_len;
            else               ch  <= nxt_ch;
          end
        end
        DATA:  if (rd) cnt <= cnt - LEN_W'(1);
        DRAIN: ch <= nxt_ch;
        CSUM:  if (!fifod_full) seq <= seq + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer with channel FIFO models
// and a fifod byte capture.
module tb_adc_frame_packer;
  localparam int NUM_CH = 4;
  localparam int LEN_W  = 10;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    fs;
  logic                    fd;
  logic                    err;
  logic [7:0]              dev_kind;
  logic [NUM_CH-1:0]       ch_mask;
  logic [NUM_CH*LEN_W-1:0] ch_len;
  logic [NUM_CH-1:0]       ch_rxen;
  logic [NUM_CH*8-1:0]     ch_rxd = '0;
  logic                    fifod_full;
  logic                    fifod_txen;
  logic [7:0]              fifod_txd;
  logic [11:0]             data_len;

  always #5 clk = ~clk;

  adc_frame_packer #(.NUM_CH(NUM_CH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd), .err(err),
    .dev_kind(dev_kind), .ch_mask(ch_mask), .ch_len(ch_len),
    .ch_rxen(ch_rxen), .ch_rxd(ch_rxd),
    .fifod_full(fifod_full), .fifod_txen(fifod_txen),
    .fifod_txd(fifod_txd), .data_len(data_len)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [7:0]        chq [NUM_CH][$];
  logic [7:0]        cap [$];
  int                n_wr, n_rd, rd_full, wr_stuck, hot_bad;
  logic              prev_full = 1'b0;
  logic [NUM_CH-1:0] rxen_s = '0;

  always @(negedge clk) begin
    #1;
    rxen_s = ch_rxen;
    if (fifod_txen) begin
      cap.push_back(fifod_txd);
      n_wr++;
      if (fifod_full && prev_full) wr_stuck++;
    end
    if (ch_rxen != '0) begin
      n_rd++;
      if (fifod_full) rd_full++;
      if (!$onehot(ch_rxen)) hot_bad++;
    end
    prev_full = fifod_full;
  end

  always @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rxen_s[i]) begin
        if (chq[i].size() > 0) ch_rxd[i*8 +: 8] <= chq[i].pop_front();
        else                   ch_rxd[i*8 +: 8] <= 8'hEE;
      end
    end
  end

  task automatic clear_mon();
    cap.delete();
    n_wr = 0; n_rd = 0; rd_full = 0; wr_stuck = 0; hot_bad = 0;
  endtask

  task automatic load_first();
    for (int i = 0; i < NUM_CH; i++) chq[i].delete();
    chq[0] = '{8'h01, 8'h02, 8'h03};
    chq[2] = '{8'h10, 8'h20};
    dev_kind = 8'hFF;
    ch_mask  = 4'b0101;
    ch_len   = '0;
    ch_len[0*LEN_W +: LEN_W] = 10'd3;
    ch_len[2*LEN_W +: LEN_W] = 10'd2;
  endtask

  task automatic run_frame(input int pat, output bit ok);
    ok = 1'b0;
    clear_mon();
    fs = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      fifod_full = (pat == 1) ? (c % 3 == 0) :
                   (pat == 2) ? (c % 4 != 3) : 1'b0;
      #2;
      if (fd) begin
        ok = 1'b1;
        break;
      end
    end
    fifod_full = 1'b0;
  endtask

  task automatic end_frame();
    bit low;
    low = 1'b0;
    @(negedge clk);
    fs = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #2;
      if (!fd) begin
        low = 1'b1;
        break;
      end
    end
    chk("fd_release", low, 1);
  endtask

  // First-frame layout; checksum is 0x3C plus the sequence number.
  task automatic chk_frame(input string tag, input logic [7:0] s);
    logic [7:0] e [13];
    e = '{8'h55, 8'hAA, 8'hFF, s, 8'h05, 8'h00, 8'h01, 8'h02,
          8'h03, 8'h02, 8'h10, 8'h20, 8'(8'h3C + s)};
    chk({tag, "_nbytes"}, cap.size(), 13);
    for (int i = 0; i < 13; i++) begin
      if (i < cap.size()) chk($sformatf("%s_b%0d", tag, i), cap[i], e[i]);
    end
    chk({tag, "_len"}, data_len, 12'd13);
    chk({tag, "_fd"}, fd, 1);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_hot"}, hot_bad, 0);
  endtask

  initial begin
    bit ok;
    int bad_runs;
    rst = 1'b1; fs = 1'b0; fifod_full = 1'b0;
    dev_kind = '0; ch_mask = '0; ch_len = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    #2;
    chk("rst_fd", fd, 0);
    chk("rst_err", err, 0);
    chk("rst_txen", fifod_txen, 0);
    chk("rst_txd", fifod_txd, 0);
    chk("rst_rxen", ch_rxen, 0);
    chk("rst_len", data_len, 0);
    rst = 1'b0;

    load_first();
    run_frame(0, ok);
    chk("f1_done", ok, 1);
    chk_frame("f1", 8'h00);
    end_frame();

    load_first();
    run_frame(0, ok);
    chk("f2_done", ok, 1);
    chk_frame("f2", 8'h01);
    end_frame();

    bad_runs = 0;
    for (int k = 2; k < 256; k++) begin
      load_first();
      run_frame(0, ok);
      if (!ok || cap.size() != 13 || cap[3] != 8'(k)) bad_runs++;
      end_frame();
    end
    chk("seq_run", bad_runs, 0);

    load_first();
    run_frame(0, ok);
    chk("wrap_done", ok, 1);
    chk_frame("wrap", 8'h00);
    end_frame();

    ch_mask = '0;
    run_frame(0, ok);
    chk("m0_done", ok, 1);
    chk("m0_err", err, 1);
    chk("m0_len", data_len, 0);
    chk("m0_wr", n_wr, 0);
    chk("m0_rd", n_rd, 0);
    end_frame();

    ch_mask = 4'hF;
    for (int i = 0; i < NUM_CH; i++) ch_len[i*LEN_W +: LEN_W] = 10'd1023;
    run_frame(0, ok);
    chk("ovf_done", ok, 1);
    chk("ovf_err", err, 1);
    chk("ovf_len", data_len, 0);
    chk("ovf_wr", n_wr, 0);
    chk("ovf_rd", n_rd, 0);
    end_frame();

    load_first();
    run_frame(1, ok);
    chk("fa_done", ok, 1);
    chk_frame("fa", 8'h01);
    chk("fa_rd_full", rd_full, 0);
    chk("fa_stuck", wr_stuck, 0);
    end_frame();

    load_first();
    run_frame(2, ok);
    chk("fb_done", ok, 1);
    chk_frame("fb", 8'h02);
    chk("fb_rd_full", rd_full, 0);
    chk("fb_stuck", wr_stuck, 0);
    end_frame();

    load_first();
    clear_mon();
    fs = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #2;
      if (ch_rxen != '0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ab_reach_data", ok, 1);
    rst = 1'b1;
    fs  = 1'b0;
    @(negedge clk);
    #2;
    clear_mon();
    chk("ab_fd", fd, 0);
    chk("ab_err", err, 0);
    chk("ab_txen", fifod_txen, 0);
    chk("ab_txd", fifod_txd, 0);
    chk("ab_rxen", ch_rxen, 0);
    chk("ab_len", data_len, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("ab_quiet", n_wr, 0);

    load_first();
    run_frame(0, ok);
    chk("ar_done", ok, 1);
    chk_frame("ar", 8'h00);
    end_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
